alu_share_arbiter: RTL and testbench

- Shares the single combinational ALU between two requesters: requester 0 is the main datapath, requester 1 is an auxiliary unit such as an address or branch helper.
- Round-robin arbitration; requests and responses use valid/ready handshakes.
- Operands and opcode are registered before the ALU is driven; result and zero are captured into response registers.
- Sits between the requesters and the ALU's read_data1/read_data2/alu_control_out inputs and its ALU_result/zero outputs.

---
 rtl/alu_share_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Three-phase transaction: accept (IDLE), evaluate (EXEC), hold response (RESP).
module alu_share_arbiter #(
  parameter int               WIDTH  = 32,
  parameter int               OPW    = 6,
  parameter logic [OPW-1:0]   MAX_OP = 6'b001101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             busy
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op;
  } req_t;

  state_e               state_q, state_d;
  logic                 prio_q, prio_d;
  logic                 gnt_q, gnt_d;
  logic                 accept;
  req_t                 op_q, op_d;
  req_t [NUM_REQ-1:0]   req;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

  assign req[0] = {req0_a, req0_b, req0_op};
  assign req[1] = {req1_a, req1_b, req1_op};

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        // prio holds the requester that did not win last, so alternation falls out
        if (req_valid[prio_q]) begin
          accept = 1'b1;
          gnt_d  = prio_q;
        end else if (req_valid[~prio_q]) begin
          accept = 1'b1;
          gnt_d  = ~prio_q;
        end
        if (accept) begin
          op_d    = req[gnt_d];
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_q.op <= MAX_OP) begin
          res_d  = alu_result;
          zero_d = alu_zero;
          err_d  = 1'b0;
        end else begin
          res_d  = '0;
          zero_d = 1'b0;
          err_d  = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready[gnt_q]) begin
          prio_d  = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_port
    assign req_ready[i]  = accept && (gnt_d == 1'(i));
    assign resp_valid[i] = (state_q == RESP) && (gnt_q == 1'(i));
  end

  assign alu_a       = op_q.a;
  assign alu_b       = op_q.b;
  assign alu_op      = op_q.op;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios then random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;
  localparam int W   = 32;
  localparam int OPW = 6;
  localparam int MAXOP = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [1:0]     req_valid, req_ready, resp_valid, resp_ready;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0] req0_op, req1_op, alu_op;
  logic [W-1:0]   resp_result, alu_a, alu_b, alu_result;
  logic           resp_zero, resp_err, alu_zero, busy;

  int n_chk  = 0;
  int n_fail = 0;

  alu_share_arbiter #(.WIDTH(W), .OPW(OPW), .MAX_OP(6'b001101)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  // Stand-in ALU; illegal opcodes still produce a nonzero value so the DUT must drop it.
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [OPW-1:0] op);
    case (op)
      6'd0:    return a + b;
      6'd1:    return a - b;
      6'd2:    return a & b;
      6'd3:    return a | b;
      6'd4:    return a ^ b;
      6'd10:   return a - b;
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);
  assign alu_zero   = (alu_result == '0);

  // Reference model: one transaction in flight, age = edges since acceptance.
  int             m_age = -1;
  int             m_who = 0;
  int             m_prio = 0;
  logic [W-1:0]   m_a = '0, m_b = '0, e_res = '0;
  logic [OPW-1:0] m_op = '0;
  logic           e_zero = 1'b0, e_err = 1'b0;

  function automatic int pick_f(input logic [1:0] v, input int p);
    if (v[p])   return p;
    if (v[1-p]) return 1 - p;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cyc();
    int p;
    logic [1:0] e_rdy, e_rv;
    #1;
    p     = pick_f(req_valid, m_prio);
    e_rdy = (m_age < 0 && p >= 0) ? 2'(1 << p) : 2'b00;
    e_rv  = (m_age >= 1) ? 2'(1 << m_who) : 2'b00;
    chk("req_ready",   64'(req_ready),   64'(e_rdy));
    chk("resp_valid",  64'(resp_valid),  64'(e_rv));
    chk("busy",        64'(busy),        64'(m_age >= 0));
    chk("alu_a",       64'(alu_a),       64'(m_a));
    chk("alu_b",       64'(alu_b),       64'(m_b));
    chk("alu_op",      64'(alu_op),      64'(m_op));
    chk("resp_result", 64'(resp_result), 64'(e_res));
    chk("resp_zero",   64'(resp_zero),   64'(e_zero));
    chk("resp_err",    64'(resp_err),    64'(e_err));
  endtask

  task automatic tick();
    int p;
    p = pick_f(req_valid, m_prio);
    if (reset) begin
      m_age = -1; m_prio = 0; m_who = 0;
      m_a = '0; m_b = '0; m_op = '0;
      e_res = '0; e_zero = 1'b0; e_err = 1'b0;
    end else if (m_age < 0) begin
      if (p >= 0) begin
        m_who = p;
        m_a   = (p == 0) ? req0_a  : req1_a;
        m_b   = (p == 0) ? req0_b  : req1_b;
        m_op  = (p == 0) ? req0_op : req1_op;
        m_age = 0;
      end
    end else if (m_age == 0) begin
      if (int'(m_op) <= MAXOP) begin
        e_res  = alu_f(m_a, m_b, m_op);
        e_zero = (e_res == '0);
        e_err  = 1'b0;
      end else begin
        e_res = '0; e_zero = 1'b0; e_err = 1'b1;
      end
      m_age = 1;
    end else if (resp_ready[m_who]) begin
      m_age  = -1;
      m_prio = 1 - m_who;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    check_cyc();
    tick();
  endtask

  task automatic drain();
    req_valid = 2'b00; resp_ready = 2'b11;
    repeat (4) step();
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    @(posedge clk); #1;
    step();                        // reset state checked by the model
    reset = 1'b0;

    // ADD 5+7 from requester 0
    req_valid = 2'b01; req0_a = 5; req0_b = 7; req0_op = 6'd0; resp_ready = 2'b01;
    check_cyc(); chk("t1_ready", 64'(req_ready), 64'(2'b01)); tick();
    req_valid = 2'b00;
    step();
    check_cyc();
    chk("t1_valid",  64'(resp_valid),  64'(2'b01));
    chk("t1_result", 64'(resp_result), 64'd12);
    chk("t1_err",    64'(resp_err),    64'd0);
    tick();
    step();

    // Both requesters saturating, fresh priority
    reset = 1'b1; step(); reset = 1'b0;
    req_valid = 2'b11; resp_ready = 2'b11;
    req0_a = 10;    req0_b = 3;    req0_op = 6'd1;
    req1_a = 'hF0;  req1_b = 'h0F; req1_op = 6'd3;
    for (int i = 0; i < 9; i++) begin
      check_cyc();
      if (i == 0) chk("t2_gnt0", 64'(req_ready), 64'(2'b01));
      if (i == 3) chk("t2_gnt1", 64'(req_ready), 64'(2'b10));
      if (i == 6) chk("t2_gnt2", 64'(req_ready), 64'(2'b01));
      if (i == 2) chk("t2_res0", 64'(resp_result), 64'd7);
      if (i == 5) chk("t2_res1", 64'(resp_result), 64'hFF);
      tick();
    end
    drain();

    // BEQ from requester 1 with a stalled response
    req_valid = 2'b10; req1_a = 9; req1_b = 9; req1_op = 6'd10; resp_ready = 2'b00;
    step();
    req_valid = 2'b11;
    step();
    for (int i = 0; i < 4; i++) begin
      check_cyc();
      chk("t3_hold_valid", 64'(resp_valid), 64'(2'b10));
      chk("t3_hold_zero",  64'(resp_zero),  64'd1);
      chk("t3_no_accept",  64'(req_ready),  64'(2'b00));
      tick();
    end
    resp_ready = 2'b01;            // wrong bit must be ignored
    step();
    resp_ready = 2'b10;
    step();
    check_cyc(); chk("t3_idle", 64'(busy), 64'd0); tick();
    drain();

    // Illegal opcode, then a legal ADD
    req_valid = 2'b01; req0_a = 1; req0_b = 2; req0_op = 6'h3F; resp_ready = 2'b01;
    step(); req_valid = 2'b00; step();
    check_cyc();
    chk("t4_err", 64'(resp_err), 64'd1);
    chk("t4_res", 64'(resp_result), 64'd0);
    tick();
    req_valid = 2'b01; req0_op = 6'd0;
    step(); req_valid = 2'b00; step();
    check_cyc();
    chk("t4_err2", 64'(resp_err), 64'd0);
    chk("t4_res2", 64'(resp_result), 64'd3);
    tick();
    step();

    // Reset while in EXEC
    req_valid = 2'b10; req1_op = 6'd2; resp_ready = 2'b00;
    step();
    req_valid = 2'b11; reset = 1'b1;
    step();
    reset = 1'b0;
    check_cyc();
    chk("t5_valid", 64'(resp_valid), 64'(2'b00));
    chk("t5_busy",  64'(busy),       64'd0);
    chk("t5_op",    64'(alu_op),     64'd0);
    chk("t5_gnt",   64'(req_ready),  64'(2'b01));
    tick();
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      req_valid  = 2'($urandom_range(0, 3));
      resp_ready = 2'($urandom_range(0, 3));
      req0_a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      req0_b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      req1_a = W'($urandom_range(0, 7));
      req1_b = W'($urandom_range(0, 7));
      req0_op = OPW'($urandom_range(0, 19));
      req1_op = ($urandom_range(0, 7) == 0) ? 6'h3F : OPW'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
